imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader_word_assembler.sv | 42 ++++
 rtl/imem_loader.sv | 153 +++++++++++++++
 tb/tb_imem_loader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        RUN
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    // Matches the core's PC increment, so consecutive writes land on consecutive fetches.
    localparam int WORD_STRIDE = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word and pulses word_ready_o
// in the cycle after the last byte of a word has been accepted.
module imem_loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic        last_o,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  byteIdx_q;
    logic [31:0] word_q;
    logic        wordReady_q;

    always_comb begin
        last_o = accept_i && (byteIdx_q == LAST_IDX);
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            byteIdx_q   <= '0;
            word_q      <= '0;
            wordReady_q <= 1'b0;
        end else begin
            wordReady_q <= last_o;
            if (accept_i) begin
                word_q[{byteIdx_q, 3'b000} +: 8] <= byte_i;
                byteIdx_q                        <= byteIdx_q + 2'd1;
            end
        end
    end

    assign word_o       = word_q;
    assign word_ready_o = wordReady_q;

endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a byte stream, holding the core in reset until done.
// Optional receive timeout enabled by defining IMEM_LOADER_TIMEOUT_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 8,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_req_i,
    input  logic [ADDR_WIDTH:0]   word_count_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    output logic                  mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  cpu_rst_o,
    output logic                  cpu_start_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e              state_q, state_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic [ADDR_WIDTH:0] wordIdx_q, wordIdx_d;
    logic [31:0]         memAddr_q, memAddr_d;
    logic                err_q, err_d;
    logic                byteReady_q, cpuRst_q, cpuStart_q, busy_q, done_q;
    logic                accept, lastByte, sessionClear, timeout, countOk;

    always_comb begin
        accept  = byte_valid_i && byteReady_q;
        countOk = (word_count_i != '0) && (word_count_i <= MAX_COUNT);
    end

`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idleCnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != RECV || accept) begin
            idleCnt_q <= '0;
        end else begin
            idleCnt_q <= idleCnt_q + 1'b1;
        end
    end

    always_comb begin
        timeout = (state_q == RECV) && !accept && (idleCnt_q == TW'(TIMEOUT_CYCLES - 1));
    end
`else
    always_comb begin
        timeout = 1'b0;
    end
`endif

    imem_loader_word_assembler u_assembler (
        .clk_i        (clk_i),
        .clear_i      (rst_i || sessionClear),
        .accept_i     (accept),
        .byte_i       (byte_data_i),
        .last_o       (lastByte),
        .word_o       (mem_wdata_o),
        .word_ready_o (mem_we_o)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        wordIdx_d    = wordIdx_q;
        memAddr_d    = memAddr_q;
        err_d        = err_q;
        sessionClear = 1'b0;
        case (state_q)
            IDLE, RUN: begin
                if (load_req_i) begin
                    if (countOk) begin
                        count_d      = word_count_i;
                        wordIdx_d    = '0;
                        memAddr_d    = BASE_ADDR;
                        err_d        = 1'b0;
                        sessionClear = 1'b1;
                        state_d      = RECV;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RECV: begin
                if (lastByte) begin
                    state_d = WRITE;
                end else if (timeout) begin
                    err_d        = 1'b1;
                    sessionClear = 1'b1;
                    state_d      = IDLE;
                end
            end
            WRITE: begin
                if (wordIdx_q + 1'b1 == count_q) begin
                    state_d = RUN;
                end else begin
                    wordIdx_d = wordIdx_q + 1'b1;
                    memAddr_d = memAddr_q + 32'(WORD_STRIDE);
                    state_d   = RECV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            wordIdx_q   <= '0;
            memAddr_q   <= BASE_ADDR;
            err_q       <= 1'b0;
            byteReady_q <= 1'b0;
            cpuRst_q    <= 1'b1;
            cpuStart_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wordIdx_q   <= wordIdx_d;
            memAddr_q   <= memAddr_d;
            err_q       <= err_d;
            byteReady_q <= (state_d == RECV);
            cpuRst_q    <= (state_d != RUN);
            cpuStart_q  <= (state_d == RUN);
            busy_q      <= (state_d == RECV) || (state_d == WRITE);
            done_q      <= (state_d == RUN);
        end
    end

    assign byte_ready_o = byteReady_q;
    assign mem_addr_o   = memAddr_q;
    assign cpu_rst_o    = cpuRst_q;
    assign cpu_start_o  = cpuStart_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: session-level model plus directed literal checks.
module tb_imem_loader;

    localparam int          AW   = 8;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          TO   = 16;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          load_req_i = 1'b0;
    logic [AW:0]   word_count_i = '0;
    logic          byte_valid_i = 1'b0;
    logic [7:0]    byte_data_i = '0;
    logic          byte_ready_o, mem_we_o, cpu_rst_o, cpu_start_o, busy_o, done_o, err_o;
    logic [31:0]   mem_addr_o, mem_wdata_o;

    imem_loader #(
        .ADDR_WIDTH     (AW),
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_req_i   (load_req_i),
        .word_count_i (word_count_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .cpu_rst_o    (cpu_rst_o),
        .cpu_start_o  (cpu_start_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Session-level model: what the loader must be doing given the handshake history.
    bit          modelValid = 0;
    bit          mBusy, mDone, mErr, mWe;
    logic [31:0] mAddr, mData;
    int          mCount, mWordsDone, mIdle;
    logic [7:0]  mBuf[$];
    int          acceptTotal = 0;
    logic [63:0] writeLog[$];

    always @(negedge clk_i) begin
        if (mem_we_o === 1'b1) writeLog.push_back({mem_addr_o, mem_wdata_o});
        if (!rst_i && byte_valid_i && byte_ready_o) acceptTotal++;
        if (modelValid) begin
            checkOutput("mem_we", 32'(mem_we_o), 32'(mWe));
            if (mWe) begin
                checkOutput("mem_addr", mem_addr_o, mAddr);
                checkOutput("mem_wdata", mem_wdata_o, mData);
            end
            checkOutput("byte_ready", 32'(byte_ready_o), 32'(mBusy && !mWe));
            checkOutput("busy", 32'(busy_o), 32'(mBusy));
            checkOutput("done", 32'(done_o), 32'(mDone));
            checkOutput("cpu_rst", 32'(cpu_rst_o), 32'(!mDone));
            checkOutput("cpu_start", 32'(cpu_start_o), 32'(mDone));
            checkOutput("err", 32'(err_o), 32'(mErr));
        end
        if (rst_i) begin
            modelValid = 1;
            mBusy = 0; mDone = 0; mErr = 0; mWe = 0;
            mWordsDone = 0; mIdle = 0; mCount = 0;
            mBuf.delete();
        end else if (mWe) begin
            mWe = 0;
            mIdle = 0;
            mWordsDone++;
            if (mWordsDone == mCount) begin
                mBusy = 0;
                mDone = 1;
            end
        end else if (mBusy) begin
            if (byte_valid_i) begin
                mIdle = 0;
                mBuf.push_back(byte_data_i);
                if (mBuf.size() == 4) begin
                    mWe   = 1;
                    mData = {mBuf[3], mBuf[2], mBuf[1], mBuf[0]};
                    mAddr = BASE + 32'(4 * mWordsDone);
                    mBuf.delete();
                end
            end
`ifdef IMEM_LOADER_TIMEOUT_EN
            else begin
                mIdle++;
                if (mIdle == TO) begin
                    mErr  = 1;
                    mBusy = 0;
                    mBuf.delete();
                end
            end
`endif
        end else if (load_req_i) begin
            if (int'(word_count_i) >= 1 && int'(word_count_i) <= (1 << AW)) begin
                mBusy = 1; mDone = 0; mErr = 0;
                mCount = int'(word_count_i);
                mWordsDone = 0; mIdle = 0;
                mBuf.delete();
            end else begin
                mErr = 1;
            end
        end
    end

    task automatic resetDut();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic pulseLoad(input int count);
        load_req_i   = 1'b1;
        word_count_i = (AW+1)'(count);
        @(posedge clk_i);
        #1 load_req_i = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_i);
            if (byte_ready_o) begin
                @(posedge clk_i);
                #1 byte_valid_i = 1'b0;
                repeat (gap) begin
                    @(posedge clk_i);
                    #1;
                end
                return;
            end
        end
        byte_valid_i = 1'b0;
        checkOutput("byteAcceptTimeout", 32'(byte_ready_o), 32'd1);
    endtask

    task automatic sendWord(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) applyStimulus(w[8*k +: 8], gap);
    endtask

    task automatic waitDone(input string name);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_i);
            if (done_o) break;
        end
        checkOutput(name, 32'(done_o), 32'd1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkLog(input string name, input int idx, input logic [31:0] addr, input logic [31:0] data);
        if (idx < writeLog.size()) begin
            checkOutput({name, "_addr"}, writeLog[idx][63:32], addr);
            checkOutput({name, "_data"}, writeLog[idx][31:0], data);
        end else begin
            checkOutput({name, "_present"}, 32'(writeLog.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int logBase, accBase;

        // Reset values
        resetDut();
        checkOutput("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
        checkOutput("rst_addr", mem_addr_o, BASE);
        checkOutput("rst_wdata", mem_wdata_o, 32'd0);
        checkOutput("rst_ready", 32'(byte_ready_o), 32'd0);

        // Two words back-to-back
        logBase = writeLog.size();
        accBase = acceptTotal;
        pulseLoad(2);
        sendWord(32'h0000_0013, 0);
        sendWord(32'h0010_0093, 0);
        waitDone("t1_done");
        checkLog("t1_w0", logBase, 32'h0, 32'h0000_0013);
        checkLog("t1_w1", logBase + 1, 32'h4, 32'h0010_0093);
        checkOutput("t1_writes", 32'(writeLog.size() - logBase), 32'd2);
        checkOutput("t1_accepts", 32'(acceptTotal - accBase), 32'd8);
        checkOutput("t1_cpu_rst", 32'(cpu_rst_o), 32'd0);

        // Same load with valid toggling every other cycle
        logBase = writeLog.size();
        accBase = acceptTotal;
        pulseLoad(2);
        sendWord(32'h0000_0013, 1);
        sendWord(32'h0010_0093, 1);
        waitDone("t2_done");
        checkLog("t2_w0", logBase, 32'h0, 32'h0000_0013);
        checkLog("t2_w1", logBase + 1, 32'h4, 32'h0010_0093);
        checkOutput("t2_accepts", 32'(acceptTotal - accBase), 32'd8);

        // Out-of-range counts
        resetDut();
        pulseLoad(0);
        checkOutput("t3_err0", 32'(err_o), 32'd1);
        checkOutput("t3_busy0", 32'(busy_o), 32'd0);
        pulseLoad((1 << AW) + 1);
        checkOutput("t3_errBig", 32'(err_o), 32'd1);
        checkOutput("t3_cpuRst", 32'(cpu_rst_o), 32'd1);
        logBase = writeLog.size();
        pulseLoad(1);
        checkOutput("t3_errCleared", 32'(err_o), 32'd0);
        sendWord(32'hA5C3_0F1E, 0);
        waitDone("t3_done");
        checkLog("t3_w0", logBase, 32'h0, 32'hA5C3_0F1E);

        // Reset in the middle of word 1
        resetDut();
        logBase = writeLog.size();
        pulseLoad(2);
        sendWord(32'h0403_0201, 0);
        applyStimulus(8'h55, 0);
        applyStimulus(8'h66, 0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        checkOutput("t4_busy", 32'(busy_o), 32'd0);
        checkOutput("t4_cpuRst", 32'(cpu_rst_o), 32'd1);
        checkOutput("t4_writes", 32'(writeLog.size() - logBase), 32'd1);
        logBase = writeLog.size();
        pulseLoad(1);
        sendWord(32'h4433_2211, 0);
        waitDone("t4_done");
        checkLog("t4_w0", logBase, 32'h0, 32'h4433_2211);

        // Reload from RUN
        logBase = writeLog.size();
        pulseLoad(1);
        checkOutput("t5_cpuRst", 32'(cpu_rst_o), 32'd1);
        checkOutput("t5_done", 32'(done_o), 32'd0);
        sendWord(32'hDEAD_BEEF, 0);
        waitDone("t5_doneAgain");
        checkLog("t5_w0", logBase, 32'h0, 32'hDEAD_BEEF);
        checkOutput("t5_cpuStart", 32'(cpu_start_o), 32'd1);

        // Stall after one byte
        resetDut();
        logBase = writeLog.size();
        pulseLoad(1);
        applyStimulus(8'h77, 0);
        repeat (20) begin
            @(posedge clk_i);
            #1;
        end
`ifdef IMEM_LOADER_TIMEOUT_EN
        checkOutput("t6_err", 32'(err_o), 32'd1);
        checkOutput("t6_busy", 32'(busy_o), 32'd0);
        checkOutput("t6_cpuRst", 32'(cpu_rst_o), 32'd1);
        checkOutput("t6_writes", 32'(writeLog.size() - logBase), 32'd0);
`else
        checkOutput("t6_err", 32'(err_o), 32'd0);
        checkOutput("t6_busy", 32'(busy_o), 32'd1);
        applyStimulus(8'hAA, 0);
        applyStimulus(8'hBB, 0);
        applyStimulus(8'hCC, 0);
        waitDone("t6_done");
        checkLog("t6_w0", logBase, 32'h0, 32'hCCBB_AA77);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
